mem_arbiter: RTL and testbench

Arbitrates the single multi-cycle main memory between the I-cache and D-cache miss handlers of the pipelined CPU. Sequences 8-word block fills: issues one word address per cycle to the pipelined memory and steers the returning words to the owning cache with word index and done strobes. Also performs single-word D-side write-through stores. Cache FSMs hold their request until the matching done or ack.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the main memory between I-cache and D-cache block fills and D-side write-through stores.
// Optional macro ROUND_ROBIN_ARB_EN: alternate fill grants between I and D when both are pending.
module mem_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_miss_req,
  input  logic [ADDR_W-1:0]              i_miss_addr,
  input  logic                           d_miss_req,
  input  logic [ADDR_W-1:0]              d_miss_addr,
  input  logic                           d_wr_req,
  input  logic [ADDR_W-1:0]              d_wr_addr,
  input  logic [15:0]                    d_wr_data,
  output logic [15:0]                    fill_data,
  output logic                           i_fill_valid,
  output logic                           d_fill_valid,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                           i_fill_done,
  output logic                           d_fill_done,
  output logic                           d_wr_ack,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [15:0]                    mem_data_in,
  input  logic [15:0]                    mem_data_out,
  input  logic                           mem_data_valid
);

  localparam int WORD_W = $clog2(BLOCK_WORDS);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(2 * BLOCK_WORDS - 1);
  // Returns can only land while still issuing if the memory answers before the block is fully issued.
  localparam logic RX_DURING_ISSUE = (MEM_LATENCY < BLOCK_WORDS);

  typedef enum logic [1:0] {IDLE, FILL_ISSUE, FILL_WAIT, WRITE} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  owner_t              fill_owner;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [WORD_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [WORD_W-1:0]   recv_cnt_q, recv_cnt_d;
  logic                rx_ok;
`ifdef ROUND_ROBIN_ARB_EN
  owner_t              last_fill_owner_q, last_fill_owner_d;
`endif

  assign fill_data = mem_data_out;
  assign fill_word = recv_cnt_q;

  // Fill grant between the two miss handlers; stores are handled ahead of this.
  always_comb begin
`ifdef ROUND_ROBIN_ARB_EN
    if (d_miss_req && i_miss_req) begin
      fill_owner = (last_fill_owner_q == OWN_I) ? OWN_D : OWN_I;
    end else begin
      fill_owner = d_miss_req ? OWN_D : OWN_I;
    end
`else
    fill_owner = d_miss_req ? OWN_D : OWN_I;
`endif
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d      = state_q;
    owner_d      = owner_q;
    base_d       = base_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
`ifdef ROUND_ROBIN_ARB_EN
    last_fill_owner_d = last_fill_owner_q;
`endif
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    i_fill_done  = 1'b0;
    d_fill_done  = 1'b0;
    d_wr_ack     = 1'b0;
    rx_ok        = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_wr_req) begin
          state_d = WRITE;
        end else if (d_miss_req || i_miss_req) begin
          owner_d     = fill_owner;
          base_d      = ((fill_owner == OWN_D) ? d_miss_addr : i_miss_addr) & BLOCK_MASK;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FILL_ISSUE;
`ifdef ROUND_ROBIN_ARB_EN
          last_fill_owner_d = fill_owner;
`endif
        end
      end
      WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = d_wr_addr;
        mem_data_in = d_wr_data;
        d_wr_ack    = 1'b1;
        state_d     = IDLE;
      end
      FILL_ISSUE: begin
        mem_en      = 1'b1;
        mem_addr    = base_q | ADDR_W'({issue_cnt_q, 1'b0});
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == LAST_WORD) state_d = FILL_WAIT;
        rx_ok       = RX_DURING_ISSUE;
      end
      FILL_WAIT: rx_ok = 1'b1;
      default:   state_d = IDLE;
    endcase

    // Returned words are steered to whichever cache owns the fill in progress.
    if (rx_ok && mem_data_valid) begin
      i_fill_valid = (owner_q == OWN_I);
      d_fill_valid = (owner_q == OWN_D);
      recv_cnt_d   = recv_cnt_q + 1'b1;
      if (recv_cnt_q == LAST_WORD) begin
        i_fill_done = i_fill_valid;
        d_fill_done = d_fill_valid;
        state_d     = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
`ifdef ROUND_ROBIN_ARB_EN
      last_fill_owner_q <= OWN_I;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
`ifdef ROUND_ROBIN_ARB_EN
      last_fill_owner_q <= last_fill_owner_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model, pipelined memory model, directed and random traffic.
module tb_mem_arbiter;
  localparam int B = 8;
  localparam int K_IDLE = 0, K_WRITE = 1, K_FILL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss_req = 1'b0, d_miss_req = 1'b0, d_wr_req = 1'b0;
  logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
  logic [15:0] fill_data, mem_addr, mem_data_in;
  logic [15:0] mem_data_out = '0;
  logic        mem_data_valid = 1'b0;
  logic        i_fill_valid, d_fill_valid, i_fill_done, d_fill_done, d_wr_ack, mem_en, mem_wr;
  logic [2:0]  fill_word;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .fill_data(fill_data), .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .fill_word(fill_word), .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .d_wr_ack(d_wr_ack), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a * 16'd7) ^ 16'h5A5A;
  endfunction

  // Pipelined memory: a read issued in cycle c returns in cycle c+mem_lat.
  int          mem_lat = 4;
  bit          spur_en = 1'b0;
  int          ret_cyc[64] = '{default: -1};
  logic [15:0] ret_dat[64];

  always @(negedge clk) begin
    if (!rst && mem_en && !mem_wr) begin
      ret_cyc[(cyc + mem_lat) % 64] = cyc + mem_lat;
      ret_dat[(cyc + mem_lat) % 64] = memf(mem_addr);
    end
  end

  // Model state (transaction level).
  int          m_kind = K_IDLE;
  bit          m_owner = 1'b0;
  bit          m_last = 1'b0;
  logic [15:0] m_base = '0, m_waddr = '0, m_wdata = '0;
  logic [15:0] m_issue[$];
  int          m_rx = 0;
  bit          s_i_done = 1'b0, s_d_done = 1'b0, s_ack = 1'b0;
  bit          done_q[$];

  always @(posedge clk) begin
    int idx;
    #1;
    idx = cyc % 64;
    mem_data_valid = 1'b0;
    mem_data_out   = 16'($urandom);
    if (ret_cyc[idx] == cyc) begin
      mem_data_valid = 1'b1;
      mem_data_out   = ret_dat[idx];
    end else if (spur_en && m_kind != K_FILL && $urandom_range(0, 5) == 0) begin
      mem_data_valid = 1'b1;
    end
  end

  // Compare process: expected outputs for this cycle, then advance the model on this cycle's inputs.
  always @(negedge clk) begin
    logic        e_en, e_wr, e_iv, e_dv, e_id, e_dd, e_ack;
    logic [15:0] e_addr, e_din;
    bit          own;
    e_en = 0; e_wr = 0; e_iv = 0; e_dv = 0; e_id = 0; e_dd = 0; e_ack = 0;
    e_addr = '0; e_din = '0;
    if (rst) begin
      m_kind = K_IDLE; m_issue.delete(); m_rx = 0; m_last = 1'b0; m_owner = 1'b0;
      check("rst_fill_word", fill_word, 0);
    end else if (m_kind == K_WRITE) begin
      e_en = 1; e_wr = 1; e_addr = m_waddr; e_din = m_wdata; e_ack = 1;
    end else if (m_kind == K_FILL) begin
      if (m_issue.size() > 0) begin
        e_en = 1; e_addr = m_issue[0];
      end
      if (mem_data_valid) begin
        e_iv = !m_owner; e_dv = m_owner;
        e_id = e_iv && (m_rx == B - 1);
        e_dd = e_dv && (m_rx == B - 1);
        check("fill_word", fill_word, m_rx);
        check("fill_word_data", fill_data, memf(m_base + 16'(2 * m_rx)));
      end
    end
    check("mem_en", mem_en, e_en);
    check("mem_wr", mem_wr, e_wr);
    check("mem_addr", mem_addr, e_addr);
    check("mem_data_in", mem_data_in, e_din);
    check("d_wr_ack", d_wr_ack, e_ack);
    check("i_fill_valid", i_fill_valid, e_iv);
    check("d_fill_valid", d_fill_valid, e_dv);
    check("i_fill_done", i_fill_done, e_id);
    check("d_fill_done", d_fill_done, e_dd);
    check("fill_data", fill_data, mem_data_out);

    if (!rst) begin
      if (m_kind == K_WRITE) begin
        m_kind = K_IDLE;
      end else if (m_kind == K_FILL) begin
        if (m_issue.size() > 0) void'(m_issue.pop_front());
        if (mem_data_valid) begin
          if (m_rx == B - 1) m_kind = K_IDLE;
          m_rx++;
        end
      end else if (d_wr_req) begin
        m_kind = K_WRITE; m_waddr = d_wr_addr; m_wdata = d_wr_data;
      end else if (d_miss_req || i_miss_req) begin
`ifdef ROUND_ROBIN_ARB_EN
        own = (d_miss_req && i_miss_req) ? !m_last : d_miss_req;
        m_last = own;
`else
        own = d_miss_req;
`endif
        m_owner = own;
        m_base  = (own ? d_miss_addr : i_miss_addr) & 16'hFFF0;
        m_issue.delete();
        for (int k = 0; k < B; k++) m_issue.push_back(m_base + 16'(2 * k));
        m_rx   = 0;
        m_kind = K_FILL;
      end
    end
    if (i_fill_done) done_q.push_back(1'b0);
    if (d_fill_done) done_q.push_back(1'b1);
    s_i_done = i_fill_done; s_d_done = d_fill_done; s_ack = d_wr_ack;
  end

  // Stimulus helpers: requesters drop after their done/ack unless auto_drop is off.
  bit auto_drop = 1'b1;
  int t0 = 0;

  task automatic step();
    @(posedge clk); #1;
    if (auto_drop) begin
      if (s_i_done) i_miss_req = 1'b0;
      if (s_d_done) d_miss_req = 1'b0;
      if (s_ack)    d_wr_req   = 1'b0;
    end
  endtask

  task automatic go_to(input int n);
    while (cyc < t0 + n) step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    i_miss_req = 0; d_miss_req = 0; d_wr_req = 0;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_seq[4];
    int rr_start;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_mem_en", mem_en, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_fill_word", fill_word, 0);

    // Single I fill at default latency.
    step(); i_miss_req = 1; i_miss_addr = 16'h1236; t0 = cyc;
    go_to(0);  check("t1_no_access_req_cycle", mem_en, 0);
    go_to(1);  check("t1_first_addr", mem_addr, 16'h1230);
    go_to(5);  check("t1_first_valid", {i_fill_valid, fill_word}, {1'b1, 3'd0});
    go_to(8);  check("t1_last_addr", mem_addr, 16'h123E);
    go_to(11); check("t1_no_early_done", i_fill_done, 0);
    go_to(12); check("t1_done", {i_fill_done, fill_word}, {1'b1, 3'd7});
    go_to(13); check("t1_idle_after", mem_en, 0);

    // Simultaneous misses: D first, then I.
    idle(3);
    step(); i_miss_req = 1; i_miss_addr = 16'h2004; d_miss_req = 1; d_miss_addr = 16'h3458; t0 = cyc;
    go_to(1);  check("t2_d_first_addr", mem_addr, 16'h3450);
    go_to(5);  check("t2_d_valid", {d_fill_valid, i_fill_valid}, 2'b10);
    go_to(12); check("t2_d_done", d_fill_done, 1);
    go_to(13); check("t2_idle_gap", mem_en, 0);
    go_to(14); check("t2_i_first_addr", mem_addr, 16'h2000);
    go_to(25); check("t2_i_done", {i_fill_done, d_fill_done}, 2'b10);

    // Store wins over a pending D miss.
    idle(3);
    step(); d_wr_req = 1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
    d_miss_req = 1; d_miss_addr = 16'h0104; t0 = cyc;
    go_to(1);
    check("t3_wr", {mem_en, mem_wr, d_wr_ack}, 3'b111);
    check("t3_wr_addr", mem_addr, 16'h0040);
    check("t3_wr_data", mem_data_in, 16'hBEEF);
    go_to(2);  check("t3_gap", mem_en, 0);
    go_to(3);  check("t3_fill_addr", {mem_wr, mem_addr}, {1'b0, 16'h0100});
    go_to(14); check("t3_fill_done", d_fill_done, 1);

    // Asynchronous reset in the middle of a fill.
    idle(3);
    step(); i_miss_req = 1; i_miss_addr = 16'h5550; t0 = cyc;
    go_to(8); check("t4_word3", {i_fill_valid, fill_word}, {1'b1, 3'd3});
    #2 rst = 1'b1;
    #1;
    check("t4_rst_valid", i_fill_valid, 0);
    check("t4_rst_mem", {mem_en, mem_addr}, 0);
    check("t4_rst_word", fill_word, 0);
    i_miss_req = 0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); check("t4_stale_ignored", i_fill_valid, 0);
    idle(6);
    step(); i_miss_req = 1; i_miss_addr = 16'h5550; t0 = cyc;
    go_to(1);  check("t4_refill_addr", mem_addr, 16'h5550);
    go_to(5);  check("t4_refill_word0", {i_fill_valid, fill_word}, {1'b1, 3'd0});
    go_to(12); check("t4_refill_done", i_fill_done, 1);

    // One-cycle memory latency: returns overlap issuing.
    idle(4);
    mem_lat = 1;
    step(); i_miss_req = 1; i_miss_addr = 16'h0A0A; t0 = cyc;
    go_to(2);
    check("t5_overlap", {mem_en, i_fill_valid, fill_word}, {1'b1, 1'b1, 3'd0});
    check("t5_overlap_addr", mem_addr, 16'h0A02);
    go_to(8); check("t5_no_early_done", i_fill_done, 0);
    go_to(9); check("t5_done", {i_fill_done, fill_word}, {1'b1, 3'd7});
    idle(4);
    mem_lat = 4;

    // Both misses held continuously after a D fill.
    step(); d_miss_req = 1; d_miss_addr = 16'h7000;
    for (int k = 0; k < 40 && !s_d_done; k++) step();
    check("t6_prefill_done", s_d_done, 1);
    auto_drop = 0;
    i_miss_req = 1; i_miss_addr = 16'h8000; d_miss_req = 1; d_miss_addr = 16'h9000;
    rr_start = done_q.size();
    for (int k = 0; k < 200 && done_q.size() - rr_start < 4; k++) step();
`ifdef ROUND_ROBIN_ARB_EN
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    check("t6_grant_count", (done_q.size() - rr_start >= 4), 1);
    for (int k = 0; k < 4; k++)
      if (rr_start + k < done_q.size()) check("t6_grant_order", done_q[rr_start + k], exp_seq[k]);
    auto_drop = 1;
    idle(20);

    // Random traffic at both latencies, with stray valids while not filling.
    for (int phase = 0; phase < 2; phase++) begin
      mem_lat = (phase == 0) ? 4 : 1;
      spur_en = 1'b1;
      for (int n = 0; n < ((phase == 0) ? 2500 : 1000); n++) begin
        step();
        if (!i_miss_req && $urandom_range(0, 5) == 0) begin
          i_miss_req = 1; i_miss_addr = 16'($urandom);
        end
        if (!d_miss_req && $urandom_range(0, 5) == 0) begin
          d_miss_req = 1; d_miss_addr = 16'($urandom);
        end
        if (!d_wr_req && $urandom_range(0, 9) == 0) begin
          d_wr_req = 1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
        end
        if (m_kind == K_FILL && $urandom_range(0, 31) == 0) begin
          if (m_owner) d_miss_req = 0;
          else         i_miss_req = 0;
        end
      end
      spur_en = 1'b0;
      idle(20);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
